// File: rtl/ecc_pkg.sv
// Shared widths and serializer state encoding for the ECC datapath I/O blocks.
package ecc_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned NIBBLES = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_X = 2'd1,
    SEND_Y = 2'd2
  } ser_state_e;

endpackage : ecc_pkg

// File: rtl/nibble_shift_reg.sv
// Parallel-load shift register holding {x,y}; shifts left one slice per beat
// and exposes the most significant slice as the outgoing nibble.
module nibble_shift_reg #(
  parameter int unsigned NIB_W   = 4,
  parameter int unsigned NIBBLES = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         load_i,
  input  logic                         shift_i,
  input  logic [2*NIB_W*NIBBLES-1:0]   data_i,
  output logic [NIB_W-1:0]             tap_o
);

  localparam int unsigned FRAME_W = 2 * NIB_W * NIBBLES;

  logic [FRAME_W-1:0] sreg_q;

  // Load has priority so a back-to-back frame replaces the drained register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sreg_q <= '0;
    end else if (load_i) begin
      sreg_q <= data_i;
    end else if (shift_i) begin
      sreg_q <= {sreg_q[FRAME_W-NIB_W-1:0], {NIB_W{1'b0}}};
    end
  end

  assign tap_o = sreg_q[FRAME_W-1 -: NIB_W];

endmodule : nibble_shift_reg

// File: rtl/kp_serializer.sv
// Streams the kP result (x then y) out as 16 nibbles, MS nibble first.
module kp_serializer #(
  parameter int unsigned NIB_W   = 4,
  parameter int unsigned NIBBLES = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic [NIB_W*NIBBLES-1:0]   i_x,
  input  logic [NIB_W*NIBBLES-1:0]   i_y,
  output logic                       o_busy,
  output logic                       o_ready,
  output logic [NIB_W-1:0]           o_kP,
  output logic                       o_first,
  output logic                       o_last
);

  import ecc_pkg::ser_state_e;
  import ecc_pkg::IDLE;
  import ecc_pkg::SEND_X;
  import ecc_pkg::SEND_Y;

  localparam int unsigned CNT_W   = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NIBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(NIBBLES - 2);

  ser_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic              first_q;
  logic              last_q;
  logic              busy_q;

  logic              last_beat;
  logic              accept;
  logic              load;
  logic              shift;
  logic [NIB_W-1:0]  tap;

  // A new result is taken when idle, or on the final nibble of a frame.
  always_comb begin
    last_beat = 1'b0;
    accept    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    last_beat = (state_q == SEND_Y) && (cnt_q == CNT_MAX);
    accept    = i_valid && ((state_q == IDLE) || last_beat);
    load      = accept;
    shift     = (state_q != IDLE) && !accept;
  end

  // Control FSM, nibble counter and registered output flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      if (accept) begin
        state_q <= SEND_X;
        cnt_q   <= '0;
        ready_q <= 1'b1;
        first_q <= 1'b1;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= IDLE;
          end
          SEND_X: begin
            cnt_q   <= cnt_q + CNT_W'(1);
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            if (cnt_q == CNT_MAX) begin
              state_q <= SEND_Y;
            end
          end
          SEND_Y: begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_beat) begin
              state_q <= IDLE;
            end else begin
              ready_q <= 1'b1;
              last_q  <= (cnt_q == CNT_PRE);
              busy_q  <= (cnt_q != CNT_PRE);
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  nibble_shift_reg #(
    .NIB_W   (NIB_W),
    .NIBBLES (NIBBLES)
  ) u_sreg (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .load_i  (load),
    .shift_i (shift),
    .data_i  ({i_x, i_y}),
    .tap_o   (tap)
  );

  assign o_ready = ready_q;
  assign o_first = first_q;
  assign o_last  = last_q;
  assign o_busy  = busy_q;
  assign o_kP    = ready_q ? tap : '0;

endmodule : kp_serializer

// File: tb/tb_kp_serializer.sv
// Bench for kp_serializer: directed scenarios plus random traffic against a
// queue-based model of the nibble stream.
module tb_kp_serializer;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [31:0] x;
  logic [31:0] y;
  logic        busy;
  logic        ready;
  logic [3:0]  kp;
  logic        first;
  logic        last;

  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct packed {
    logic [3:0] kp;
    logic       first;
    logic       last;
  } beat_t;

  beat_t exp_q[$];

  kp_serializer #(.NIB_W(4), .NIBBLES(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .i_x     (x),
    .i_y     (y),
    .o_busy  (busy),
    .o_ready (ready),
    .o_kP    (kp),
    .o_first (first),
    .o_last  (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs with what the model says is on the pins now.
  task automatic check_outputs(input string tag);
    logic [3:0] e_kp;
    logic       e_rdy, e_first, e_last, e_busy;
    e_rdy   = (exp_q.size() > 0);
    e_kp    = e_rdy ? exp_q[0].kp    : 4'h0;
    e_first = e_rdy ? exp_q[0].first : 1'b0;
    e_last  = e_rdy ? exp_q[0].last  : 1'b0;
    e_busy  = e_rdy && !exp_q[0].last;
    chk({tag, ".ready"}, 32'(ready), 32'(e_rdy));
    chk({tag, ".kp"},    32'(kp),    32'(e_kp));
    chk({tag, ".first"}, 32'(first), 32'(e_first));
    chk({tag, ".last"},  32'(last),  32'(e_last));
    chk({tag, ".busy"},  32'(busy),  32'(e_busy));
  endtask

  // One clock: check, advance the model with the current inputs, step to next negedge.
  task automatic cycle(input string tag);
    logic [63:0] frame;
    logic        take;
    beat_t       b;
    check_outputs(tag);
    take = valid && ((exp_q.size() == 0) || exp_q[0].last);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (take) begin
      frame = {x, y};
      for (int i = 0; i < 16; i++) begin
        b.kp    = 4'(frame >> (60 - 4 * i));
        b.first = (i == 0);
        b.last  = (i == 15);
        exp_q.push_back(b);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic pulse(input string tag, input logic [31:0] vx, input logic [31:0] vy);
    x = vx; y = vy; valid = 1'b1;
    cycle(tag);
    valid = 1'b0;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; valid = 1'b0; x = '0; y = '0;
    @(negedge clk);
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run("idle", 2);

    // Single frame 1..F,0
    pulse("single", 32'h1234_5678, 32'h9ABC_DEF0);
    chk("single.n0", 32'(kp), 32'h1);
    run("single", 18);

    // Back-to-back: second request during the o_last cycle
    pulse("b2b_a", 32'h1234_5678, 32'h9ABC_DEF0);
    guard = 0;
    while (!(exp_q.size() == 1) && guard < 40) begin
      cycle("b2b_a"); guard++;
    end
    chk("b2b.reach_last", 32'(exp_q.size()), 32'd1);
    pulse("b2b_b", 32'hFFFF_0000, 32'h0000_FFFF);
    chk("b2b.first_F", 32'(kp), 32'hF);
    chk("b2b.first_flag", 32'(first), 32'h1);
    run("b2b_b", 18);

    // Request during a running frame is ignored
    pulse("ign", 32'hCAFE_F00D, 32'h0123_4567);
    run("ign", 4);
    pulse("ign_req", 32'hDEAD_BEEF, 32'h0000_0000);
    run("ign", 20);

    // Reset mid-frame
    pulse("rst", 32'hA5A5_5A5A, 32'h3C3C_C3C3);
    run("rst", 9);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_outputs("rst_async");
    @(posedge clk);
    @(negedge clk);
    check_outputs("rst_hold");
    rst_n = 1'b1;
    run("post_rst", 1);
    pulse("post_rst", 32'h0000_0001, 32'h0000_0002);
    run("post_rst", 18);

    // Held request: frames repeat back-to-back
    x = 32'h0F1E_2D3C; y = 32'h4B5A_6978; valid = 1'b1;
    run("held", 40);
    valid = 1'b0;
    run("held_drain", 20);

    // Random traffic, including requests while busy
    for (int i = 0; i < 300; i++) begin
      x = $urandom; y = $urandom;
      valid = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end
    valid = 1'b0;
    run("rand_drain", 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_kp_serializer
